cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 The block SHALL have the port: clk  in  1  clock, all state updates on posedge.
REQ-003 The block SHALL have the port: rst  in  1  synchronous active-low reset; 0 at posedge resets all state.
REQ-004 The block SHALL have the port: rdy  in  1  global enable; 0 freezes all state.
REQ-005 The block SHALL have the port: clear  in  1  pipeline flush from ROB.
REQ-006 The block SHALL have the ports: alu_valid in 1, alu_tag in 4, alu_data in 32, alu_ready out 1  ALU result producer.
REQ-007 The block SHALL have the ports: lsb_valid in 1, lsb_tag in 4, lsb_data in 32, lsb_ready out 1  LSB result producer.
REQ-008 The block SHALL have the ports: br_valid in 1, br_tag in 4, br_data in 32, br_jump in 1, br_pc in 32, br_ready out 1  branch producer.
REQ-009 The block SHALL have the ports: cdb_valid out 1, cdb_src out 2, cdb_tag out 4, cdb_data out 32, cdb_jump out 1, cdb_pc out 32  registered single CDB broadcast.
REQ-010 The block SHALL have the port: busy  out 1  any FIFO non-empty.

Function
REQ-011 Each source SHALL own a 2-entry FIFO; the entry is {tag, data, jump, pc}; ALU/LSB entries store jump=0, pc=0.
REQ-012 x_ready SHALL be 1 iff that FIFO count < 2, rdy=1, and clear=0; ready is combinational from the count only, with no same-cycle pop credit.
REQ-013 Enqueue SHALL occur at posedge when x_valid & x_ready.
REQ-014 Each cycle the arbiter SHALL select one non-empty FIFO head by round-robin from rr_ptr in order ALU(0)->LSB(1)->BR(2).
REQ-015 On a grant, the arbiter SHALL pop that head, load the cdb_* registers, set cdb_valid=1, and set rr_ptr=(grant+1) mod 3.
REQ-016 When no FIFO is non-empty, the block SHALL set cdb_valid=0 at the next posedge, hold the other cdb_* at their last value, and leave rr_ptr unchanged.
REQ-017 Latency SHALL be: a result accepted at edge N reaches the CDB at edge N+1 at the earliest (visible the cycle after acceptance); there is no bypass of an empty FIFO.
REQ-018 The block SHALL provide 1 broadcast per cycle maximum.
REQ-019 The block SHALL sustain 1/cycle when one source streams, since a FIFO at count 1 plus a pop keeps ready high.
REQ-020 A push and a pop on the same FIFO in one cycle SHALL leave the count unchanged and keep FIFO order.
REQ-021 FIFO pointers SHALL be 1-bit and wrap 1->0.
REQ-022 FIFO count SHALL be 2-bit, saturating at 2 by construction; overflow SHALL be impossible since ready gates the push.
REQ-023 When clear=1 at posedge (rdy=1), the block SHALL empty all FIFOs, drop incoming valids, set cdb_valid=0, and set rr_ptr=0.
REQ-024 Flush SHALL override grant and enqueue in the same cycle.
REQ-025 When rdy=0, the block SHALL hold FIFOs, rr_ptr, and all cdb_* registers, keep a valid cdb asserted, force ready outputs to 0, and perform no grant.
REQ-026 busy SHALL be the OR of the three count != 0 terms, combinational.

Reset
REQ-027 When rst=0 at posedge, the block SHALL set: counts=0, pointers=0, rr_ptr=0, cdb_valid=0, cdb_src=0, cdb_tag=0, cdb_data=0, cdb_jump=0, cdb_pc=0.
REQ-028 Reset SHALL apply regardless of rdy.
REQ-029 Reset mid-stream SHALL discard buffered results with no broadcast.
REQ-030 Reset SHALL have priority over clear.

Structure
REQ-031 The shared package SHALL hold TAG_W=4, DATA_W=32, ADDR_W=32, and the source codes SRC_ALU=0, SRC_LSB=1, SRC_BR=2.
REQ-032 A sub-module cdb_src_fifo (2-entry, parameterised width, push/pop/flush, count/head outputs) SHALL be instantiated three times.
REQ-033 Round-robin select and the output register SHALL live in cdb_arbiter.

Verification
REQ-034 Scenario: all three valid same cycle from reset (ALU tag 1, LSB tag 2, BR tag 3 jump=1 pc=0x100) -> CDB sources 0,1,2 on three consecutive cycles; the BR beat has cdb_jump=1 and cdb_pc=0x100.
REQ-035 Scenario: ALU streams tags 0..7 back-to-back, others idle -> alu_ready stays 1 and the CDB shows tags 0..7 in order, one per cycle, with no bubble after the first.
REQ-036 Scenario: LSB pushes 3 results while ALU holds a constant backlog -> LSB and ALU alternate; lsb_ready drops to 0 when the LSB count reaches 2; no loss or reorder.
REQ-037 Scenario: with 2 entries buffered in each FIFO, assert clear with alu_valid=1 -> next cycle busy=0 and cdb_valid=0; the dropped tag never appears; the next grant is ALU first.
REQ-038 Scenario: with rdy=0 for 3 cycles while cdb_valid=1 tag 5 -> outputs held, readies 0, counts unchanged; the stream resumes exactly after rdy=1.
REQ-039 Scenario: rst=0 mid-stream with busy=1 -> all outputs at reset values next cycle; the first result pushed after release reaches the CDB at edge N+1.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, source codes and round-robin helpers for the common data bus arbiter.
package cdb_arbiter_pkg;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_LSB = 2'd1;
  localparam logic [1:0] SRC_BR  = 2'd2;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              jump;
    logic [ADDR_W-1:0] pc;
  } cdb_entry_t;

  localparam int ENTRY_W = $bits(cdb_entry_t);

  typedef struct packed {
    logic       found;
    logic [1:0] src;
  } rr_pick_t;

  // First non-empty source at or after ptr, scanning ALU -> LSB -> BR cyclically.
  function automatic rr_pick_t rr_pick(input logic [2:0] nonempty, input logic [1:0] ptr);
    rr_pick_t   res;
    logic [1:0] cand;
    logic       hit;
    res = '{found: 1'b0, src: SRC_ALU};
    for (int i = 0; i < 3; i++) begin
      cand      = 2'((int'(ptr) + i) % 3);
      hit       = !res.found && nonempty[cand];
      res.src   = hit ? cand : res.src;
      res.found = res.found | hit;
    end
    return res;
  endfunction

  function automatic logic [1:0] rr_next(input logic [1:0] src);
    logic [1:0] nxt;
    case (src)
      SRC_ALU: nxt = SRC_LSB;
      SRC_LSB: nxt = SRC_BR;
      default: nxt = SRC_ALU;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Two-entry result FIFO for one CDB producer; en_i freezes it, flush_i empties it.
module cdb_src_fifo #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [1:0]   count_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_q, wr_d;
  logic         rd_q, rd_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push_s, do_pop_s, wr_en_s;

  // Pointer and count next-state; flush beats push/pop, disabled means hold.
  always_comb begin
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    do_push_s = push_i && (cnt_q != 2'd2);
    do_pop_s  = pop_i && (cnt_q != 2'd0);
    wr_en_s   = 1'b0;
    if (en_i && flush_i) begin
      wr_d  = 1'b0;
      rd_d  = 1'b0;
      cnt_d = 2'd0;
    end else if (en_i) begin
      wr_en_s = do_push_s;
      wr_d    = do_push_s ? ~wr_q : wr_q;
      rd_d    = do_pop_s ? ~rd_q : rd_q;
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; validity is tracked by the count, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_q[wr_q] <= push_data_i;
    end
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter merging ALU, LSB and branch results onto one registered CDB broadcast.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              alu_valid,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsb_valid,
  input  logic [TAG_W-1:0]  lsb_tag,
  input  logic [DATA_W-1:0] lsb_data,
  output logic              lsb_ready,
  input  logic              br_valid,
  input  logic [TAG_W-1:0]  br_tag,
  input  logic [DATA_W-1:0] br_data,
  input  logic              br_jump,
  input  logic [ADDR_W-1:0] br_pc,
  output logic              br_ready,
  output logic              cdb_valid,
  output logic [1:0]        cdb_src,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              cdb_jump,
  output logic [ADDR_W-1:0] cdb_pc,
  output logic              busy
);

  cdb_entry_t push_s [3];
  cdb_entry_t head_s [3];
  logic [1:0] cnt_s  [3];
  logic [2:0] valid_s, ready_s, push_en_s, pop_s, nonempty_s;
  rr_pick_t   pick_s;
  logic       grant_s;

  logic       cdb_valid_q, cdb_valid_d;
  logic [1:0] cdb_src_q, cdb_src_d;
  cdb_entry_t cdb_q, cdb_d;
  logic [1:0] rr_q, rr_d;

  assign valid_s = {br_valid, lsb_valid, alu_valid};
  assign push_s[SRC_ALU] = '{tag: alu_tag, data: alu_data, jump: 1'b0, pc: {ADDR_W{1'b0}}};
  assign push_s[SRC_LSB] = '{tag: lsb_tag, data: lsb_data, jump: 1'b0, pc: {ADDR_W{1'b0}}};
  assign push_s[SRC_BR]  = '{tag: br_tag, data: br_data, jump: br_jump, pc: br_pc};

  assign pick_s  = rr_pick(nonempty_s, rr_q);
  assign grant_s = rdy && !clear && pick_s.found;

  for (genvar gi = 0; gi < 3; gi++) begin : g_fifo
    // Ready depends only on the current count: a same-cycle pop gives no credit.
    assign ready_s[gi]    = (cnt_s[gi] < 2'd2) && rdy && !clear;
    assign push_en_s[gi]  = valid_s[gi] && ready_s[gi];
    assign nonempty_s[gi] = (cnt_s[gi] != 2'd0);
    assign pop_s[gi]      = grant_s && (pick_s.src == 2'(gi));

    cdb_src_fifo #(.W(ENTRY_W)) u_fifo (
      .clk_i       (clk),
      .rst_ni      (rst),
      .en_i        (rdy),
      .flush_i     (clear),
      .push_i      (push_en_s[gi]),
      .push_data_i (push_s[gi]),
      .pop_i       (pop_s[gi]),
      .count_o     (cnt_s[gi]),
      .head_o      (head_s[gi])
    );
  end

  // Broadcast and round-robin next-state: flush, then grant, then idle; rdy=0 holds.
  always_comb begin
    cdb_valid_d = cdb_valid_q;
    cdb_src_d   = cdb_src_q;
    cdb_d       = cdb_q;
    rr_d        = rr_q;
    if (rdy && clear) begin
      cdb_valid_d = 1'b0;
      rr_d        = SRC_ALU;
    end else if (grant_s) begin
      cdb_valid_d = 1'b1;
      cdb_src_d   = pick_s.src;
      rr_d        = rr_next(pick_s.src);
      case (pick_s.src)
        SRC_LSB: cdb_d = head_s[SRC_LSB];
        SRC_BR:  cdb_d = head_s[SRC_BR];
        default: cdb_d = head_s[SRC_ALU];
      endcase
    end else if (rdy) begin
      cdb_valid_d = 1'b0;
    end else begin
      cdb_valid_d = cdb_valid_q;
    end
  end

  // CDB output and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cdb_valid_q <= 1'b0;
      cdb_src_q   <= 2'd0;
      cdb_q       <= '{tag: {TAG_W{1'b0}}, data: {DATA_W{1'b0}}, jump: 1'b0, pc: {ADDR_W{1'b0}}};
      rr_q        <= 2'd0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_src_q   <= cdb_src_d;
      cdb_q       <= cdb_d;
      rr_q        <= rr_d;
    end
  end

  assign alu_ready = ready_s[SRC_ALU];
  assign lsb_ready = ready_s[SRC_LSB];
  assign br_ready  = ready_s[SRC_BR];
  assign cdb_valid = cdb_valid_q;
  assign cdb_src   = cdb_src_q;
  assign cdb_tag   = cdb_q.tag;
  assign cdb_data  = cdb_q.data;
  assign cdb_jump  = cdb_q.jump;
  assign cdb_pc    = cdb_q.pc;
  assign busy      = |nonempty_s;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed table-driven bench for cdb_arbiter plus a hand-written freeze/flush sequence.
module tb_cdb_arbiter;

  localparam logic        Y  = 1'b1;
  localparam logic        N  = 1'b0;
  localparam logic [31:0] P0 = 32'h0;

  logic        clk, rst, rdy, clear;
  logic        alu_valid, lsb_valid, br_valid, br_jump;
  logic [3:0]  alu_tag, lsb_tag, br_tag;
  logic [31:0] alu_data, lsb_data, br_data, br_pc;
  logic        alu_ready, lsb_ready, br_ready;
  logic        cdb_valid, cdb_jump, busy;
  logic [1:0]  cdb_src;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data, cdb_pc;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic rs, rd, cl;
    logic av; logic [3:0] at;
    logic lv; logic [3:0] lt;
    logic bv; logic [3:0] bt; logic bj; logic [31:0] bpc;
    logic [2:0] rd3; logic chk;
    logic cv; logic [1:0] cs; logic [3:0] ct; logic [31:0] cd;
    logic cj; logic [31:0] cpc; logic bsy;
  } vec_t;

  vec_t tbl[$];

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsb_valid(lsb_valid), .lsb_tag(lsb_tag), .lsb_data(lsb_data), .lsb_ready(lsb_ready),
    .br_valid(br_valid), .br_tag(br_tag), .br_data(br_data), .br_jump(br_jump),
    .br_pc(br_pc), .br_ready(br_ready),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_jump(cdb_jump), .cdb_pc(cdb_pc), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data payload each producer drives for a given tag, so the broadcast data is predictable.
  function automatic logic [31:0] dat(input logic [1:0] s, input logic [3:0] t);
    case (s)
      2'd0:    return {4'hA, 24'h000000, t};
      2'd1:    return {4'hB, 24'h000000, t};
      default: return {4'hC, 24'h000000, t};
    endcase
  endfunction

  function automatic vec_t mk(
    input logic rs, rd, cl,
    input logic av, input logic [3:0] at,
    input logic lv, input logic [3:0] lt,
    input logic bv, input logic [3:0] bt, input logic bj, input logic [31:0] bpc,
    input logic [2:0] rd3, input logic chk,
    input logic cv, input logic [1:0] cs, input logic [3:0] ct,
    input logic cj, input logic [31:0] cpc, input logic bsy, input logic oz);
    vec_t v;
    v.rs = rs; v.rd = rd; v.cl = cl;
    v.av = av; v.at = at; v.lv = lv; v.lt = lt;
    v.bv = bv; v.bt = bt; v.bj = bj; v.bpc = bpc;
    v.rd3 = rd3; v.chk = chk;
    v.cv = cv; v.cs = cs; v.ct = ct; v.cj = cj; v.cpc = cpc; v.bsy = bsy;
    v.cd = oz ? 32'h0 : dat(cs, ct);
    return v;
  endfunction

  function automatic vec_t idle(input logic [2:0] rd3, input logic cv, input logic [1:0] cs,
                                input logic [3:0] ct, input logic cj, input logic [31:0] cpc,
                                input logic bsy);
    return mk(Y, Y, N, N, 4'd0, N, 4'd0, N, 4'd0, N, P0, rd3, Y, cv, cs, ct, cj, cpc, bsy, N);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst = v.rs; rdy = v.rd; clear = v.cl;
    alu_valid = v.av; alu_tag = v.at; alu_data = dat(2'd0, v.at);
    lsb_valid = v.lv; lsb_tag = v.lt; lsb_data = dat(2'd1, v.lt);
    br_valid = v.bv; br_tag = v.bt; br_data = dat(2'd2, v.bt); br_jump = v.bj; br_pc = v.bpc;
  endtask

  initial begin
    int w;
    // reset, with and without rdy
    tbl.push_back(mk(N,Y,N, N,4'd0, N,4'd0, N,4'd0,N,P0, 3'b111,N, N,2'd0,4'd0,N,P0,N,Y));
    tbl.push_back(mk(N,N,N, N,4'd0, N,4'd0, N,4'd0,N,P0, 3'b000,Y, N,2'd0,4'd0,N,P0,N,Y));
    // all three valid in one cycle from reset
    tbl.push_back(mk(Y,Y,N, Y,4'd1, Y,4'd2, Y,4'd3,Y,32'h100, 3'b111,Y, N,2'd0,4'd0,N,P0,Y,Y));
    tbl.push_back(idle(3'b111, Y,2'd0,4'd1,N,P0,Y));
    tbl.push_back(idle(3'b111, Y,2'd1,4'd2,N,P0,Y));
    tbl.push_back(idle(3'b111, Y,2'd2,4'd3,Y,32'h100,N));
    tbl.push_back(idle(3'b111, N,2'd2,4'd3,Y,32'h100,N));
    // ALU streams tags 0..7 back to back
    tbl.push_back(mk(Y,Y,N, Y,4'd0, N,4'd0, N,4'd0,N,P0, 3'b111,Y, N,2'd2,4'd3,Y,32'h100,Y,N));
    for (int k = 1; k < 8; k++)
      tbl.push_back(mk(Y,Y,N, Y,4'(k), N,4'd0, N,4'd0,N,P0, 3'b111,Y, Y,2'd0,4'(k-1),N,P0,Y,N));
    tbl.push_back(idle(3'b111, Y,2'd0,4'd7,N,P0,N));
    tbl.push_back(idle(3'b111, N,2'd0,4'd7,N,P0,N));
    // LSB pushes 4,5,6 against an ALU backlog; producers hold valid until accepted
    tbl.push_back(mk(Y,Y,N, Y,4'd8,  Y,4'd4, N,4'd0,N,P0, 3'b111,Y, N,2'd0,4'd7,N,P0,Y,N));
    tbl.push_back(mk(Y,Y,N, Y,4'd9,  Y,4'd5, N,4'd0,N,P0, 3'b111,Y, Y,2'd1,4'd4,N,P0,Y,N));
    tbl.push_back(mk(Y,Y,N, Y,4'd10, Y,4'd6, N,4'd0,N,P0, 3'b011,Y, Y,2'd0,4'd8,N,P0,Y,N));
    tbl.push_back(mk(Y,Y,N, Y,4'd10, N,4'd0, N,4'd0,N,P0, 3'b101,Y, Y,2'd1,4'd5,N,P0,Y,N));
    tbl.push_back(mk(Y,Y,N, Y,4'd11, N,4'd0, N,4'd0,N,P0, 3'b011,Y, Y,2'd0,4'd9,N,P0,Y,N));
    tbl.push_back(mk(Y,Y,N, Y,4'd11, N,4'd0, N,4'd0,N,P0, 3'b111,Y, Y,2'd1,4'd6,N,P0,Y,N));
    tbl.push_back(idle(3'b011, Y,2'd0,4'd10,N,P0,Y));
    tbl.push_back(idle(3'b111, Y,2'd0,4'd11,N,P0,N));
    // fill as far as the arbiter allows, then flush with a dropped ALU tag 14
    tbl.push_back(mk(Y,Y,N, Y,4'd12, Y,4'd7, Y,4'd9,N,32'h200,  3'b111,Y, N,2'd0,4'd11,N,P0,Y,N));
    tbl.push_back(mk(Y,Y,N, Y,4'd13, Y,4'd8, Y,4'd10,Y,32'h300, 3'b111,Y, Y,2'd1,4'd7,N,P0,Y,N));
    tbl.push_back(mk(Y,Y,Y, Y,4'd14, N,4'd0, N,4'd0,N,P0, 3'b000,Y, N,2'd1,4'd7,N,P0,N,N));
    tbl.push_back(idle(3'b111, N,2'd1,4'd7,N,P0,N));
    tbl.push_back(mk(Y,Y,N, Y,4'd15, Y,4'd1, Y,4'd2,N,32'h40, 3'b111,Y, N,2'd1,4'd7,N,P0,Y,N));
    tbl.push_back(idle(3'b111, Y,2'd0,4'd15,N,P0,Y));
    tbl.push_back(idle(3'b111, Y,2'd1,4'd1,N,P0,Y));
    tbl.push_back(idle(3'b111, Y,2'd2,4'd2,N,32'h40,N));
    // rdy low for three cycles while tag 5 is on the bus
    tbl.push_back(mk(Y,Y,N, Y,4'd5, Y,4'd6, N,4'd0,N,P0, 3'b111,Y, N,2'd2,4'd2,N,32'h40,Y,N));
    tbl.push_back(mk(Y,Y,N, Y,4'd7, N,4'd0, N,4'd0,N,P0, 3'b111,Y, Y,2'd0,4'd5,N,P0,Y,N));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(Y,N,N, Y,4'd8, N,4'd0, N,4'd0,N,P0, 3'b000,Y, Y,2'd0,4'd5,N,P0,Y,N));
    tbl.push_back(idle(3'b111, Y,2'd1,4'd6,N,P0,Y));
    tbl.push_back(idle(3'b111, Y,2'd0,4'd7,N,P0,N));
    // reset (together with clear) mid-stream, then a fresh push
    tbl.push_back(mk(Y,Y,N, Y,4'd1, Y,4'd2, Y,4'd3,Y,32'h500, 3'b111,Y, N,2'd0,4'd7,N,P0,Y,N));
    tbl.push_back(idle(3'b111, Y,2'd1,4'd2,N,P0,Y));
    tbl.push_back(mk(N,Y,Y, Y,4'd9, N,4'd0, N,4'd0,N,P0, 3'b000,Y, N,2'd0,4'd0,N,P0,N,Y));
    tbl.push_back(mk(Y,Y,N, Y,4'd4, N,4'd0, N,4'd0,N,P0, 3'b111,Y, N,2'd0,4'd0,N,P0,Y,Y));
    tbl.push_back(idle(3'b111, Y,2'd0,4'd4,N,P0,N));
    tbl.push_back(idle(3'b111, N,2'd0,4'd4,N,P0,N));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      #1;
      if (tbl[i].chk)
        check($sformatf("row%0d_ready", i), {125'h0, alu_ready, lsb_ready, br_ready}, {125'h0, tbl[i].rd3});
      @(posedge clk);
      #1;
      check($sformatf("row%0d_cdb", i),
            {55'h0, cdb_valid, cdb_src, cdb_tag, cdb_data, cdb_jump, cdb_pc, busy},
            {55'h0, tbl[i].cv, tbl[i].cs, tbl[i].ct, tbl[i].cd, tbl[i].cj, tbl[i].cpc, tbl[i].bsy});
    end

    // clear while rdy=0 must not flush; the buffered entry broadcasts after release
    apply(mk(Y,Y,N, Y,4'd6, N,4'd0, N,4'd0,N,P0, 3'b111,Y, N,2'd0,4'd0,N,P0,N,Y));
    @(posedge clk);
    #1;
    check("frz_push", {126'h0, cdb_valid, busy}, {126'h0, 1'b0, 1'b1});
    alu_valid = 1'b0; rdy = 1'b0; clear = 1'b1;
    #1;
    check("frz_ready", {125'h0, alu_ready, lsb_ready, br_ready}, 128'h0);
    @(posedge clk);
    #1;
    check("frz_hold", {126'h0, cdb_valid, busy}, {126'h0, 1'b0, 1'b1});
    rdy = 1'b1; clear = 1'b0;
    w = 0;
    while (!cdb_valid && w < 4) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("frz_latency", 128'(w), 128'd1);
    check("frz_beat", {88'h0, cdb_src, cdb_tag, cdb_data, busy}, {88'h0, 2'd0, 4'd6, dat(2'd0, 4'd6), 1'b0});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
